// File: rtl/move_ctrl.sv
// Grid movement controller: turns debounced direction/pause pulses into a wrapped
// x/y position that advances one cell every TICK_DIV clock cycles.
module move_ctrl #(
    parameter int TICK_DIV = 12_500_000,
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       L,
    input  logic       R,
    input  logic       U,
    input  logic       D,
    input  logic       pause,
    output logic [5:0] x,
    output logic [4:0] y,
    output logic [1:0] dir,
    output logic       step,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int             CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [5:0]     X_MAX   = 6'(GRID_W - 1);
    localparam logic [5:0]     X_HOME  = 6'(GRID_W / 2);
    localparam logic [4:0]     Y_MAX   = 5'(GRID_H - 1);
    localparam logic [4:0]     Y_HOME  = 5'(GRID_H / 2);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    pending, pending_nxt;
    logic [1:0]    dir_nxt;
    logic [5:0]    x_nxt, move_x;
    logic [4:0]    y_nxt, move_y;
    logic          step_nxt;

    logic          req_valid;
    logic [1:0]    req_dir;
    logic          req_opposite;
    logic [1:0]    pend_eff;

    // Priority decode of the press pulses: U > D > L > R.
    always_comb begin
        req_valid = U | D | L | R;
        req_dir   = DIR_RIGHT;
        if (U)
            req_dir = DIR_UP;
        else if (D)
            req_dir = DIR_DOWN;
        else if (L)
            req_dir = DIR_LEFT;
    end

    // Opposite pairs differ only in bit 0, and the check is against the committed dir.
    assign req_opposite = (req_dir == (dir ^ 2'b01));

    always_comb begin
        pend_eff = pending;
        if (req_valid && !pause && !req_opposite)
            pend_eff = req_dir;
    end

    // Candidate position one cell along pend_eff, wrapping at the grid edges.
    always_comb begin
        move_x = x;
        move_y = y;
        case (pend_eff)
            DIR_UP:    move_y = (y == 5'd0)  ? Y_MAX : y - 5'd1;
            DIR_DOWN:  move_y = (y == Y_MAX) ? 5'd0  : y + 5'd1;
            DIR_LEFT:  move_x = (x == 6'd0)  ? X_MAX : x - 6'd1;
            default:   move_x = (x == X_MAX) ? 6'd0  : x + 6'd1;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        dir_nxt     = dir;
        x_nxt       = x;
        y_nxt       = y;
        step_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && !pause) begin
                    state_nxt   = RUN;
                    dir_nxt     = req_dir;
                    pending_nxt = req_dir;
                    cnt_nxt     = '0;
                end
            end
            RUN: begin
                // Pause wins over a coinciding step edge; the counter stays at its value.
                if (pause) begin
                    state_nxt = PAUSE;
                end else begin
                    pending_nxt = pend_eff;
                    if (cnt == CNT_MAX) begin
                        cnt_nxt  = '0;
                        dir_nxt  = pend_eff;
                        x_nxt    = move_x;
                        y_nxt    = move_y;
                        step_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (pause)
                    state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= DIR_RIGHT;
            dir     <= DIR_RIGHT;
            x       <= X_HOME;
            y       <= Y_HOME;
            step    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            dir     <= dir_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
            step    <= step_nxt;
        end
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_move_ctrl.sv
// Directed self-checking bench for move_ctrl with TICK_DIV=4 on a 32x24 grid.
module tb_move_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       L, R, U, D, pause;
    logic [5:0] x;
    logic [4:0] y;
    logic [1:0] dir;
    logic       step;
    logic       running;

    int vectors     = 0;
    int miscompares = 0;

    move_ctrl #(
        .TICK_DIV(4),
        .GRID_W  (32),
        .GRID_H  (24)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .L      (L),
        .R      (R),
        .U      (U),
        .D      (D),
        .pause  (pause),
        .x      (x),
        .y      (y),
        .dir    (dir),
        .step   (step),
        .running(running)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic applyStimulus(input logic u, input logic d, input logic l,
                                 input logic r, input logic p);
        U = u; D = d; L = l; R = r; pause = p;
        tick();
        U = 1'b0; D = 1'b0; L = 1'b0; R = 1'b0; pause = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        idle_ticks(2);
        clr = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        U = 1'b0; D = 1'b0; L = 1'b0; R = 1'b0; pause = 1'b0;

        // Reset values while clr is held
        clr = 1'b1;
        idle_ticks(2);
        checkOutput("rst_x", 32'(x), 32'd16);
        checkOutput("rst_y", 32'(y), 32'd12);
        checkOutput("rst_dir", 32'(dir), 32'd3);
        checkOutput("rst_step", 32'(step), 32'd0);
        checkOutput("rst_running", 32'(running), 32'd0);
        clr = 1'b0;

        // Pause in IDLE is ignored
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("idle_pause_running", 32'(running), 32'd0);

        // Start upward, step every 4 cycles, y 12->11->10
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("start_running", 32'(running), 32'd1);
        checkOutput("start_dir", 32'(dir), 32'd0);
        checkOutput("start_y", 32'(y), 32'd12);
        checkOutput("start_step", 32'(step), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("gap1_step", 32'(step), 32'd0);
        end
        tick();
        checkOutput("step1_step", 32'(step), 32'd1);
        checkOutput("step1_y", 32'(y), 32'd11);
        checkOutput("step1_x", 32'(x), 32'd16);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("gap2_step", 32'(step), 32'd0);
        end
        tick();
        checkOutput("step2_step", 32'(step), 32'd1);
        checkOutput("step2_y", 32'(y), 32'd10);
        checkOutput("step2_x", 32'(x), 32'd16);

        // Right, then D accepted, then L rejected against committed right
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("opp_start_dir", 32'(dir), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("opp_prestep_step", 32'(step), 32'd0);
        checkOutput("opp_prestep_dir", 32'(dir), 32'd3);
        tick();
        checkOutput("opp_step", 32'(step), 32'd1);
        checkOutput("opp_dir", 32'(dir), 32'd1);
        checkOutput("opp_y", 32'(y), 32'd13);
        checkOutput("opp_x", 32'(x), 32'd16);

        // Pulse coinciding with the step edge steers that step
        idle_ticks(3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("same_edge_step", 32'(step), 32'd1);
        checkOutput("same_edge_dir", 32'(dir), 32'd2);
        checkOutput("same_edge_x", 32'(x), 32'd15);
        checkOutput("same_edge_y", 32'(y), 32'd13);

        // U and L together in IDLE: U wins
        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("prio_dir", 32'(dir), 32'd0);
        checkOutput("prio_running", 32'(running), 32'd1);

        // Right wrap 31->0, then up wrap 0->23
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(60);
        checkOutput("wrapx_pre_x", 32'(x), 32'd31);
        idle_ticks(4);
        checkOutput("wrapx_x", 32'(x), 32'd0);
        checkOutput("wrapx_step", 32'(step), 32'd1);
        checkOutput("wrapx_y", 32'(y), 32'd12);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_ticks(3);
        checkOutput("turn_up_step", 32'(step), 32'd1);
        checkOutput("turn_up_dir", 32'(dir), 32'd0);
        checkOutput("turn_up_y", 32'(y), 32'd11);
        idle_ticks(44);
        checkOutput("wrapy_pre_y", 32'(y), 32'd0);
        idle_ticks(4);
        checkOutput("wrapy_y", 32'(y), 32'd23);
        checkOutput("wrapy_step", 32'(step), 32'd1);
        checkOutput("wrapy_x", 32'(x), 32'd0);

        // Pause on the step edge, U pulses while paused, resume
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(3);
        checkOutput("pz_pre_step", 32'(step), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("pz_step", 32'(step), 32'd0);
        checkOutput("pz_running", 32'(running), 32'd0);
        checkOutput("pz_x", 32'(x), 32'd16);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("pz_hold_step", 32'(step), 32'd0);
        end
        checkOutput("pz_hold_x", 32'(x), 32'd16);
        checkOutput("pz_hold_y", 32'(y), 32'd12);
        checkOutput("pz_hold_dir", 32'(dir), 32'd3);
        checkOutput("pz_hold_running", 32'(running), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("resume_running", 32'(running), 32'd1);
        checkOutput("resume_step", 32'(step), 32'd0);
        checkOutput("resume_x", 32'(x), 32'd16);
        tick();
        checkOutput("resume_fire_step", 32'(step), 32'd1);
        checkOutput("resume_fire_x", 32'(x), 32'd17);
        checkOutput("resume_fire_dir", 32'(dir), 32'd3);
        checkOutput("resume_fire_y", 32'(y), 32'd12);

        // clr mid-RUN at counter 2, then 20 quiet cycles
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(4);
        checkOutput("mid_pre_x", 32'(x), 32'd17);
        idle_ticks(2);
        clr = 1'b1;
        #1;
        checkOutput("mid_clr_x", 32'(x), 32'd16);
        checkOutput("mid_clr_y", 32'(y), 32'd12);
        checkOutput("mid_clr_dir", 32'(dir), 32'd3);
        checkOutput("mid_clr_running", 32'(running), 32'd0);
        checkOutput("mid_clr_step", 32'(step), 32'd0);
        tick();
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("post_clr_step", 32'(step), 32'd0);
            checkOutput("post_clr_running", 32'(running), 32'd0);
        end
        checkOutput("post_clr_x", 32'(x), 32'd16);
        checkOutput("post_clr_y", 32'(y), 32'd12);
        checkOutput("post_clr_dir", 32'(dir), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
